round_sequencer: RTL

//  Sequences one round of 21: initial deal, player hit/stand, automatic dealer

---
 rtl/round_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// Sequencer for one round of 21: deal, player hit/stand, automatic dealer play
// and scoring, with every card fetched from an external source over req/valid.
module round_sequencer #(
    parameter logic [5:0] LIMIT        = 6'd21,
    parameter logic [5:0] DEALER_STAND = 6'd17,
    parameter logic [5:0] FACE_VALUE   = 6'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_round,
    input  logic       hit,
    input  logic       stand,
    input  logic       card_valid,
    input  logic [3:0] card_value,
    output logic       card_req,
    output logic [5:0] player_score,
    output logic [5:0] dealer_score,
    output logic [3:0] last_card,
    output logic [2:0] phase,
    output logic [1:0] outcome
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_DEAL_P1     = 4'd1,
        S_DEAL_D1     = 4'd2,
        S_DEAL_P2     = 4'd3,
        S_PLAYER_WAIT = 4'd4,
        S_PLAYER_REQ  = 4'd5,
        S_DEALER_REQ  = 4'd6,
        S_DEALER_EVAL = 4'd7,
        S_RESULT      = 4'd8
    } state_t;

    // Raw 0 counts as an ace; 11..15 all count as a face card.
    function automatic logic [5:0] card_points(input logic [3:0] v);
        logic [5:0] p;
        if (v == 4'd0) begin
            p = 6'd1;
        end else if (v <= 4'd10) begin
            p = {2'b00, v};
        end else begin
            p = FACE_VALUE;
        end
        return p;
    endfunction

    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[6] ? 6'd63 : s[5:0];
    endfunction

    function automatic logic [2:0] phase_of(input state_t s);
        logic [2:0] p;
        case (s)
            S_IDLE:                               p = 3'd0;
            S_DEAL_P1, S_DEAL_D1, S_DEAL_P2:      p = 3'd1;
            S_PLAYER_WAIT, S_PLAYER_REQ:          p = 3'd2;
            S_DEALER_REQ, S_DEALER_EVAL:          p = 3'd3;
            S_RESULT:                             p = 3'd4;
            default:                              p = 3'd0;
        endcase
        return p;
    endfunction

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [5:0] player_q, player_d, dealer_q, dealer_d;
    logic [3:0] last_q, last_d;
    logic [1:0] res_q, res_d, outcome_q, outcome_d;
    logic [2:0] phase_q, phase_d;
    logic [2:0] keys_sync_q, keys_sync_d, keys_prev_q, keys_prev_d;

    logic       nr_edge_s, hit_edge_s, stand_edge_s, accept_s;
    logic [5:0] add_player_s, add_dealer_s;

    assign {nr_edge_s, hit_edge_s, stand_edge_s} = keys_sync_q & ~keys_prev_q;
    assign accept_s     = req_q & card_valid;
    assign add_player_s = sat_add(player_q, card_points(card_value));
    assign add_dealer_s = sat_add(dealer_q, card_points(card_value));

    // Next-state, handshake and score update logic.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        player_d    = player_q;
        dealer_d    = dealer_q;
        last_d      = last_q;
        res_d       = res_q;
        keys_sync_d = {new_round, hit, stand};
        keys_prev_d = keys_sync_q;
        phase_d     = phase_of(state_q);
        outcome_d   = (state_q == S_RESULT) ? res_q : 2'b00;

        case (state_q)
            S_IDLE, S_RESULT: begin
                if (nr_edge_s) begin
                    state_d  = S_DEAL_P1;
                    player_d = 6'd0;
                    dealer_d = 6'd0;
                    res_d    = 2'b00;
                end else begin
                    state_d = state_q;
                end
            end
            S_DEAL_P1, S_DEAL_P2: begin
                if (accept_s) begin
                    req_d    = 1'b0;
                    last_d   = card_value;
                    player_d = add_player_s;
                    state_d  = (state_q == S_DEAL_P1) ? S_DEAL_D1 : S_PLAYER_WAIT;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_DEAL_D1: begin
                if (accept_s) begin
                    req_d    = 1'b0;
                    last_d   = card_value;
                    dealer_d = add_dealer_s;
                    state_d  = S_DEAL_P2;
                end else begin
                    req_d = 1'b1;
                end
            end
            // A player already sitting on the limit stands automatically.
            S_PLAYER_WAIT: begin
                if (stand_edge_s || (player_q == LIMIT)) begin
                    state_d = S_DEALER_REQ;
                end else if (hit_edge_s) begin
                    state_d = S_PLAYER_REQ;
                end else begin
                    state_d = S_PLAYER_WAIT;
                end
            end
            S_PLAYER_REQ: begin
                if (accept_s) begin
                    req_d    = 1'b0;
                    last_d   = card_value;
                    player_d = add_player_s;
                    if (add_player_s > LIMIT) begin
                        state_d = S_RESULT;
                        res_d   = 2'b10;
                    end else begin
                        state_d = S_PLAYER_WAIT;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            // Re-evaluated with req low after each card so the new total is seen.
            S_DEALER_REQ: begin
                if (accept_s) begin
                    req_d    = 1'b0;
                    last_d   = card_value;
                    dealer_d = add_dealer_s;
                end else if (!req_q) begin
                    if (dealer_q < DEALER_STAND) begin
                        req_d = 1'b1;
                    end else begin
                        state_d = S_DEALER_EVAL;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            S_DEALER_EVAL: begin
                state_d = S_RESULT;
                if (dealer_q > LIMIT) begin
                    res_d = 2'b01;
                end else if (player_q > dealer_q) begin
                    res_d = 2'b01;
                end else if (dealer_q > player_q) begin
                    res_d = 2'b10;
                end else begin
                    res_d = 2'b11;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            player_q    <= 6'd0;
            dealer_q    <= 6'd0;
            last_q      <= 4'd0;
            res_q       <= 2'b00;
            outcome_q   <= 2'b00;
            phase_q     <= 3'd0;
            keys_sync_q <= 3'b000;
            keys_prev_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            player_q    <= player_d;
            dealer_q    <= dealer_d;
            last_q      <= last_d;
            res_q       <= res_d;
            outcome_q   <= outcome_d;
            phase_q     <= phase_d;
            keys_sync_q <= keys_sync_d;
            keys_prev_q <= keys_prev_d;
        end
    end

    assign card_req     = req_q;
    assign player_score = player_q;
    assign dealer_score = dealer_q;
    assign last_card    = last_q;
    assign phase        = phase_q;
    assign outcome      = outcome_q;

endmodule
